// File: rtl/enemy_squadron_pkg.sv
// Shared types and screen geometry for the enemy squadron controller.
// Coordinates are widened to 11 bits for all compare/add work so nothing wraps.
package enemy_squadron_pkg;

  typedef enum logic [1:0] {
    SLOT_IDLE   = 2'd0,
    SLOT_ACTIVE = 2'd1,
    SLOT_DYING  = 2'd2
  } slot_state_t;

  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int C_W = 11;

  localparam int SCREEN_X_MIN = 0;
  localparam int SCREEN_X_MAX = 624;
  localparam int SCREEN_Y_INIT = 50;
  localparam int SCREEN_Y_LIMIT = 420;

  typedef logic [C_W-1:0] coord_t;

  function automatic coord_t clamp_c(input coord_t v, input coord_t lo, input coord_t hi);
    coord_t r;
    r = v;
    if (v < lo) r = lo;
    if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/enemy_squadron_slot.sv
// One enemy: lifecycle FSM plus x/y registers and kill/escape pulses.
//   state       | meaning
//   SLOT_IDLE   | free, allocatable, coordinates hold last value
//   SLOT_ACTIVE | on screen, moves on move_tick, can be hit
//   SLOT_DYING  | one-cycle cool-down after kill/escape, not allocatable
module enemy_squadron_slot
  import enemy_squadron_pkg::*;
#(
  parameter int Y_INIT   = SCREEN_Y_INIT,
  parameter int Y_LIMIT  = SCREEN_Y_LIMIT,
  parameter int STEP_X   = 15,
  parameter int STEP_Y   = 10,
  parameter int DEADZONE = 8,
  parameter int X_MIN    = SCREEN_X_MIN,
  parameter int X_MAX    = SCREEN_X_MAX
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           spawn_go,
  input  logic [X_W-1:0] spawn_x,
  input  logic           move_tick,
  input  logic           hit,
  input  logic [X_W-1:0] player_x,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           on_screen,
  output logic           kill_pulse,
  output logic           escape_pulse,
  output logic           idle
);

  slot_state_t state, state_nxt;
  logic [X_W-1:0] x_nxt;
  logic [Y_W-1:0] y_nxt;
  logic on_nxt, kill_nxt, esc_nxt;

  coord_t x_c, px_c, y_sum, x_left, x_right, x_track;
  logic escape;

  assign x_c    = coord_t'(x);
  assign px_c   = coord_t'(player_x);
  assign y_sum  = coord_t'(y) + coord_t'(STEP_Y);
  assign escape = (y_sum >= coord_t'(Y_LIMIT));
  assign x_left  = (x_c >= coord_t'(X_MIN + STEP_X)) ? x_c - coord_t'(STEP_X) : coord_t'(X_MIN);
  assign x_right = (x_c + coord_t'(STEP_X) > coord_t'(X_MAX)) ? coord_t'(X_MAX)
                                                                : x_c + coord_t'(STEP_X);

  // Dead zone: only steer when the player is more than DEADZONE columns away.
  always_comb begin
    x_track = x_c;
    if (px_c + coord_t'(DEADZONE) < x_c) x_track = x_left;
    else if (px_c > x_c + coord_t'(DEADZONE)) x_track = x_right;
  end

  assign idle = (state == SLOT_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= SLOT_IDLE;
      x            <= '0;
      y            <= '0;
      on_screen    <= 1'b0;
      kill_pulse   <= 1'b0;
      escape_pulse <= 1'b0;
    end else begin
      state        <= state_nxt;
      x            <= x_nxt;
      y            <= y_nxt;
      on_screen    <= on_nxt;
      kill_pulse   <= kill_nxt;
      escape_pulse <= esc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SLOT_IDLE:   if (spawn_go) state_nxt = SLOT_ACTIVE;
      SLOT_ACTIVE: if (hit || (move_tick && escape)) state_nxt = SLOT_DYING;
      SLOT_DYING:  state_nxt = SLOT_IDLE;
      default:     state_nxt = SLOT_IDLE;
    endcase
  end

  // Hit takes precedence over movement, so a hit slot freezes where it is.
  always_comb begin
    x_nxt    = x;
    y_nxt    = y;
    on_nxt   = 1'b0;
    kill_nxt = 1'b0;
    esc_nxt  = 1'b0;
    case (state)
      SLOT_IDLE: begin
        if (spawn_go) begin
          x_nxt  = spawn_x;
          y_nxt  = Y_W'(Y_INIT);
          on_nxt = 1'b1;
        end
      end
      SLOT_ACTIVE: begin
        if (hit) begin
          kill_nxt = 1'b1;
        end else if (move_tick) begin
          x_nxt = X_W'(x_track);
          if (escape) begin
            y_nxt   = Y_W'(Y_LIMIT);
            esc_nxt = 1'b1;
          end else begin
            y_nxt  = Y_W'(y_sum);
            on_nxt = 1'b1;
          end
        end else begin
          on_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/enemy_squadron.sv
// Multi-slot enemy controller: lowest-free-slot spawn allocation, hit decode,
// spawn ack/drop reporting, and N_SLOTS enemy_squadron_slot instances.
module enemy_squadron
  import enemy_squadron_pkg::*;
#(
  parameter int N_SLOTS  = 4,
  parameter int Y_INIT   = SCREEN_Y_INIT,
  parameter int Y_LIMIT  = SCREEN_Y_LIMIT,
  parameter int STEP_X   = 15,
  parameter int STEP_Y   = 10,
  parameter int DEADZONE = 8,
  parameter int X_MIN    = SCREEN_X_MIN,
  parameter int X_MAX    = SCREEN_X_MAX
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   move_tick,
  input  logic                   spawn_req,
  input  logic [X_W-1:0]         spawn_x,
  input  logic [X_W-1:0]         player_x,
  input  logic                   hit_valid,
  input  logic [2:0]             hit_idx,
  output logic [X_W*N_SLOTS-1:0] enemy_x,
  output logic [Y_W*N_SLOTS-1:0] enemy_y,
  output logic [N_SLOTS-1:0]     on_screen,
  output logic                   spawn_ack,
  output logic                   spawn_drop,
  output logic [N_SLOTS-1:0]     kill_pulse,
  output logic [N_SLOTS-1:0]     escape_pulse
);

  localparam int IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  logic [N_SLOTS-1:0] slot_idle, slot_go, slot_hit;
  logic               free_found;
  logic [X_W-1:0]     spawn_x_cl;
  logic [IDX_W-1:0]   hit_idx_lo;
  logic               hit_idx_unused;

  assign hit_idx_lo     = hit_idx[IDX_W-1:0];
  assign hit_idx_unused = ^hit_idx;
  assign spawn_x_cl = X_W'(clamp_c(coord_t'(spawn_x), coord_t'(X_MIN), coord_t'(X_MAX)));

  // Only slots already IDLE this cycle are candidates; DYING slots wait a cycle.
  always_comb begin
    slot_go    = '0;
    free_found = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (slot_idle[i] && !free_found) begin
        slot_go[i] = spawn_req;
        free_found = 1'b1;
      end
    end
  end

  always_comb begin
    slot_hit = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      slot_hit[i] = hit_valid && (int'(hit_idx_lo) == i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spawn_ack  <= 1'b0;
      spawn_drop <= 1'b0;
    end else begin
      spawn_ack  <= spawn_req && free_found;
      spawn_drop <= spawn_req && !free_found;
    end
  end

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
    enemy_squadron_slot #(
      .Y_INIT   (Y_INIT),
      .Y_LIMIT  (Y_LIMIT),
      .STEP_X   (STEP_X),
      .STEP_Y   (STEP_Y),
      .DEADZONE (DEADZONE),
      .X_MIN    (X_MIN),
      .X_MAX    (X_MAX)
    ) u_slot (
      .clk          (clk),
      .reset        (reset),
      .spawn_go     (slot_go[g]),
      .spawn_x      (spawn_x_cl),
      .move_tick    (move_tick),
      .hit          (slot_hit[g]),
      .player_x     (player_x),
      .x            (enemy_x[X_W*g +: X_W]),
      .y            (enemy_y[Y_W*g +: Y_W]),
      .on_screen    (on_screen[g]),
      .kill_pulse   (kill_pulse[g]),
      .escape_pulse (escape_pulse[g]),
      .idle         (slot_idle[g])
    );
  end

endmodule
